yin_frame_buffer: RTL and testbench

Sample-capture front end for the pitch-detection chain. It shifts incoming audio samples into a frame window of `2**WINDOW_SIZE_BITS + MAX_TAU` samples. When a frame is complete, it starts the downstream minimum-tau analyser by releasing that analyser's reset, and holds the window frozen while the analysis runs. When the analyser reports ready, it latches the tau result, re-arms the analyser, and collects `HOP_SIZE` fresh samples to form the next overlapping frame.

---
 rtl/yin_frame_buffer_if.sv | 30 +++
 rtl/yin_frame_buffer.sv | 112 +++++++++++
 tb/tb_yin_frame_buffer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/yin_frame_buffer_if.sv
// Bus bundle between the frame buffer and its sample source / analyser.
// The buffer is the slave; the surrounding logic (or a bench) is the master.
interface yin_frame_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 296
);
    logic                  sample_valid;
    logic [DATA_WIDTH-1:0] sample_in;
    logic                  sample_ready;
    logic [DATA_WIDTH-1:0] data [FRAME_LEN];
    logic                  analyzer_reset;
    logic                  analyzer_ready;
    logic [7:0]            analyzer_tau;
    logic [7:0]            tau_out;
    logic                  tau_valid;
    logic                  overrun;
    logic [15:0]           drop_count;

    modport master (
        output sample_valid, sample_in, analyzer_ready, analyzer_tau,
        input  sample_ready, data, analyzer_reset, tau_out, tau_valid,
               overrun, drop_count
    );

    modport slave (
        input  sample_valid, sample_in, analyzer_ready, analyzer_tau,
        output sample_ready, data, analyzer_reset, tau_out, tau_valid,
               overrun, drop_count
    );
endinterface

// File: rtl/yin_frame_buffer.sv
// Sliding sample window feeding the min-tau analyser: fills a frame, freezes it
// while the analyser runs, latches tau, then collects a hop of fresh samples.
module yin_frame_buffer #(
    parameter int DATA_WIDTH       = 8,
    parameter int WINDOW_SIZE_BITS = 8,
    parameter int MAX_TAU          = 40,
    parameter int HOP_SIZE         = 64
) (
    input  logic clk,
    input  logic reset,
    yin_frame_buffer_if.slave bus
);
    localparam int FRAME_LEN = 2**WINDOW_SIZE_BITS + MAX_TAU;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    localparam logic [CNT_W-1:0] C_FRAME = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] C_HOP   = CNT_W'(HOP_SIZE);

    localparam logic [0:0] S_FILL    = 1'b0;
    localparam logic [0:0] S_ANALYZE = 1'b1;

    logic [0:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_first;
    logic                  r_settle;
    logic                  r_an_reset;
    logic [7:0]            r_tau;
    logic                  r_tau_valid;
    logic                  r_overrun;
    logic [15:0]           r_drops;
    logic [DATA_WIDTH-1:0] r_data [FRAME_LEN];

    logic                  w_ready;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic [CNT_W-1:0]      w_target;
    logic                  w_frame_done;
    logic                  w_drop;
    logic                  w_result;

    assign w_ready      = (r_state == S_FILL) && !reset;
    assign w_accept     = bus.sample_valid && w_ready;
    assign w_cnt_inc    = r_cnt + CNT_W'(1);
    assign w_target     = r_first ? C_FRAME : C_HOP;
    assign w_frame_done = w_accept && (w_cnt_inc == w_target);
    assign w_drop       = (r_state == S_ANALYZE) && bus.sample_valid;
    // The analyser's ready flag is stale for one edge after its reset is released.
    assign w_result     = (r_state == S_ANALYZE) && !r_settle && bus.analyzer_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_FILL;
            r_cnt       <= '0;
            r_first     <= 1'b1;
            r_settle    <= 1'b0;
            r_an_reset  <= 1'b1;
            r_tau       <= '0;
            r_tau_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_drops     <= '0;
        end else begin
            r_tau_valid <= 1'b0;
            if (r_state == S_FILL) begin
                if (w_frame_done) begin
                    r_state    <= S_ANALYZE;
                    r_cnt      <= '0;
                    r_first    <= 1'b0;
                    r_settle   <= 1'b1;
                    r_an_reset <= 1'b0;
                end else if (w_accept) begin
                    r_cnt <= w_cnt_inc;
                end
            end else begin
                r_settle <= 1'b0;
                if (w_result) begin
                    r_tau       <= bus.analyzer_tau;
                    r_tau_valid <= 1'b1;
                    r_an_reset  <= 1'b1;
                    r_state     <= S_FILL;
                end
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
                if (r_drops != 16'hFFFF) begin
                    r_drops <= r_drops + 16'd1;
                end
            end
        end
    end

    // Oldest sample at index 0; new samples enter at the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                r_data[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < FRAME_LEN - 1; i++) begin
                r_data[i] <= r_data[i+1];
            end
            r_data[FRAME_LEN-1] <= bus.sample_in;
        end
    end

    assign bus.sample_ready   = w_ready;
    assign bus.data           = r_data;
    assign bus.analyzer_reset = r_an_reset;
    assign bus.tau_out        = r_tau;
    assign bus.tau_valid      = r_tau_valid;
    assign bus.overrun        = r_overrun;
    assign bus.drop_count     = r_drops;
endmodule

// File: tb/tb_yin_frame_buffer.sv
// Bench for yin_frame_buffer: directed frame/handshake sequences, a vector table
// for the result handshake, and random traffic against a window/phase model.
module tb_yin_frame_buffer;
    localparam int DW  = 8;
    localparam int FL  = 296;
    localparam int HOP = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    yin_frame_buffer_if #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) bus ();

    yin_frame_buffer #(
        .DATA_WIDTH(DW), .WINDOW_SIZE_BITS(8), .MAX_TAU(40), .HOP_SIZE(HOP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int ramp  = 0;

    // Reference model: window contents, phase, samples still needed, cycles spent analysing.
    int m_win [FL];
    bit m_an;
    int m_need;
    int m_age;
    int m_tau;
    bit m_tv;
    bit m_ovr;
    int m_drops;

    typedef struct {
        bit v;
        int s;
        bit ar;
        int at;
        bit e_ready;
        bit e_areset;
        bit e_tv;
        int e_tau;
    } vec_t;
    vec_t tbl [11];

    task automatic model_reset();
        for (int i = 0; i < FL; i++) m_win[i] = 0;
        m_an = 0; m_need = FL; m_age = 0; m_tau = 0; m_tv = 0; m_ovr = 0; m_drops = 0;
    endtask

    task automatic model_edge(input bit v, input int s, input bit ar, input int at);
        m_tv = 0;
        if (!m_an) begin
            if (v) begin
                for (int i = 0; i < FL - 1; i++) m_win[i] = m_win[i+1];
                m_win[FL-1] = s & 255;
                m_need--;
                if (m_need == 0) begin
                    m_an  = 1;
                    m_age = 0;
                end
            end
        end else begin
            if (v) begin
                m_ovr = 1;
                if (m_drops < 65535) m_drops++;
            end
            if (m_age >= 1 && ar) begin
                m_tau  = at & 255;
                m_tv   = 1;
                m_an   = 0;
                m_need = HOP;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_data(input string name);
        int idx;
        idx = -1;
        for (int i = 0; i < FL; i++) begin
            if (idx < 0 && int'(bus.data[i]) != m_win[i]) idx = i;
        end
        total++;
        if (idx >= 0) begin
            bad++;
            $display("FAIL %s: data[%0d] got %0d expected %0d at %0t",
                     name, idx, int'(bus.data[idx]), m_win[idx], $time);
        end
    endtask

    task automatic check_model();
        chk("sample_ready",   int'(bus.sample_ready),   int'(!m_an));
        chk("analyzer_reset", int'(bus.analyzer_reset), int'(!m_an));
        chk("tau_out",        int'(bus.tau_out),        m_tau);
        chk("tau_valid",      int'(bus.tau_valid),      int'(m_tv));
        chk("overrun",        int'(bus.overrun),        int'(m_ovr));
        chk("drop_count",     int'(bus.drop_count),     m_drops);
        chk_data("window");
    endtask

    task automatic step(input bit v, input int s, input bit ar, input int at);
        bus.sample_valid   = v;
        bus.sample_in      = s[7:0];
        bus.analyzer_ready = ar;
        bus.analyzer_tau   = at[7:0];
        @(posedge clk);
        model_edge(v, s, ar, at);
        #1;
        check_model();
    endtask

    task automatic feed(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b1, ramp, 1'b0, 0);
            ramp++;
        end
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge.
    task automatic pulse_reset();
        bus.sample_valid   = 1'b0;
        bus.analyzer_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_areset", int'(bus.analyzer_reset), 1);
        chk("ready_in_reset", int'(bus.sample_ready), 0);
        model_reset();
        chk("overrun_rst", int'(bus.overrun), 0);
        chk("drops_rst", int'(bus.drop_count), 0);
        chk_data("data_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_model();
    endtask

    initial begin
        int snap [FL];
        bus.sample_valid   = 1'b0;
        bus.sample_in      = '0;
        bus.analyzer_ready = 1'b0;
        bus.analyzer_tau   = '0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", int'(bus.sample_ready), 0);
        chk("reset_areset", int'(bus.analyzer_reset), 1);
        chk("reset_tau", int'(bus.tau_out), 0);
        chk_data("reset_data");
        reset = 1'b0;
        #1;
        check_model();

        // Initial fill with ramp 0..295.
        ramp = 0;
        feed(FL - 1);
        chk("areset_before_last", int'(bus.analyzer_reset), 1);
        feed(1);
        chk("areset_after_fill", int'(bus.analyzer_reset), 0);
        chk("ready_after_fill", int'(bus.sample_ready), 0);
        chk("data0_fill", int'(bus.data[0]), 0);
        chk("data295_fill", int'(bus.data[FL-1]), 39);

        // Result handshake: ready in the 10th ANALYZE cycle with tau 17.
        for (int r = 0; r < 9; r++) tbl[r] = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 1, 17, 1, 1, 1, 17};
        tbl[10] = '{1, 40, 0, 0, 1, 1, 0, 17};
        for (int r = 0; r < 11; r++) begin
            step(tbl[r].v, tbl[r].s, tbl[r].ar, tbl[r].at);
            chk($sformatf("tbl%0d_ready", r),  int'(bus.sample_ready),   int'(tbl[r].e_ready));
            chk($sformatf("tbl%0d_areset", r), int'(bus.analyzer_reset), int'(tbl[r].e_areset));
            chk($sformatf("tbl%0d_tv", r),     int'(bus.tau_valid),      int'(tbl[r].e_tv));
            chk($sformatf("tbl%0d_tau", r),    int'(bus.tau_out),        tbl[r].e_tau);
        end
        ramp = 297;

        // Hop of 64: 63 more after the one accepted in the table.
        feed(HOP - 2);
        chk("hop_areset_63", int'(bus.analyzer_reset), 1);
        feed(1);
        chk("hop_areset_64", int'(bus.analyzer_reset), 0);
        chk("hop_data0", int'(bus.data[0]), 64);
        chk("hop_data295", int'(bus.data[FL-1]), 103);

        // Premature ready held high from ANALYZE entry.
        step(1'b0, 0, 1'b1, 23);
        chk("premature_tv1", int'(bus.tau_valid), 0);
        chk("premature_ar1", int'(bus.analyzer_reset), 0);
        step(1'b0, 0, 1'b1, 23);
        chk("premature_tv2", int'(bus.tau_valid), 1);
        chk("premature_tau", int'(bus.tau_out), 23);
        step(1'b0, 0, 1'b0, 0);
        chk("tv_single_pulse", int'(bus.tau_valid), 0);

        // Overrun: five samples offered during ANALYZE.
        feed(HOP);
        for (int i = 0; i < FL; i++) snap[i] = m_win[i];
        for (int k = 0; k < 5; k++) step(1'b1, 8'hAA, 1'b0, 0);
        chk("overrun_set", int'(bus.overrun), 1);
        chk("drops_5", int'(bus.drop_count), 5);
        begin
            int diff;
            diff = 0;
            for (int i = 0; i < FL; i++) if (int'(bus.data[i]) != snap[i]) diff++;
            chk("frozen_window_diffs", diff, 0);
        end
        step(1'b0, 0, 1'b1, 5);
        feed(HOP);
        step(1'b0, 0, 1'b0, 0);
        step(1'b0, 0, 1'b1, 9);
        chk("overrun_sticky", int'(bus.overrun), 1);
        chk("drops_sticky", int'(bus.drop_count), 5);

        // Reset mid-ANALYZE, then a full-length refill is needed.
        feed(HOP);
        step(1'b0, 0, 1'b0, 0);
        pulse_reset();
        feed(FL - 1);
        chk("refill_areset_295", int'(bus.analyzer_reset), 1);
        feed(1);
        chk("refill_areset_296", int'(bus.analyzer_reset), 0);
        step(1'b0, 0, 1'b0, 0);
        step(1'b0, 0, 1'b1, 3);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
            end else begin
                step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
                     ($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
